// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, byte-lane bus,
// load alignment and extension, valid/ready response to the CPU.
module load_store_unit #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  input  logic [31:0] drdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t st, st_nx;

  logic        l_store;
  logic [2:0]  l_f3;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [2:0]  size;
  logic        illegal;
  logic        misal;
  logic        oor;
  logic        err;
  logic [32:0] end_addr;
  logic [31:0] sh;
  logic [31:0] load_val;

  always_comb begin
    size    = 3'd0;
    illegal = 1'b0;
    unique case (1'b1)
      (l_f3[1:0] == 2'b00): size = 3'd1;
      (l_f3[1:0] == 2'b01): size = 3'd2;
      (l_f3 == 3'b010):     size = 3'd4;
      default:              illegal = 1'b1;
    endcase
    if (l_store && l_f3[2])
      illegal = 1'b1;
  end

  // 33-bit end address so a wrap near 2^32 still counts as out of range
  assign end_addr = {1'b0, l_addr} + {30'd0, size};
  assign oor      = end_addr > 33'(MEM_BYTES);
  assign misal    = ((size == 3'd2) && l_addr[0]) ||
                    ((size == 3'd4) && (l_addr[1:0] != 2'b00));
  assign err      = illegal || misal || oor;

  assign sh = drdata >> {l_addr[1:0], 3'b000};

  always_comb begin
    load_val = 32'd0;
    unique case (1'b1)
      (l_f3 == 3'b000): load_val = {{24{sh[7]}}, sh[7:0]};
      (l_f3 == 3'b001): load_val = {{16{sh[15]}}, sh[15:0]};
      (l_f3 == 3'b010): load_val = drdata;
      (l_f3 == 3'b100): load_val = {24'd0, sh[7:0]};
      (l_f3 == 3'b101): load_val = {16'd0, sh[15:0]};
      default:          load_val = 32'd0;
    endcase
  end

  always_comb begin
    st_nx     = st;
    req_ready = 1'b0;
    daddr     = 32'd0;
    dwdata    = 32'd0;
    we        = 4'b0000;
    unique case (st)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          st_nx = ACCESS;
      end
      ACCESS: begin
        daddr = l_addr;
        if (l_store && !err) begin
          unique case (1'b1)
            (size == 3'd1): begin
              we     = 4'b0001 << l_addr[1:0];
              dwdata = {4{l_wdata[7:0]}};
            end
            (size == 3'd2): begin
              we     = 4'b0011 << l_addr[1:0];
              dwdata = {2{l_wdata[15:0]}};
            end
            default: begin
              we     = 4'b1111;
              dwdata = l_wdata;
            end
          endcase
        end
        st_nx = RESP;
      end
      RESP: begin
        if (resp_ready)
          st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  assign resp_valid = (st == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      l_store <= 1'b0;
      l_f3    <= 3'd0;
      l_addr  <= 32'd0;
      l_wdata <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      st <= st_nx;
      unique case (st)
        IDLE: begin
          if (req_valid) begin
            l_store <= req_store;
            l_f3    <= req_funct3;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
          end
        end
        ACCESS: begin
          err_q   <= err;
          rdata_q <= (err || l_store) ? 32'd0 : load_val;
        end
        RESP: begin
          if (resp_ready) begin
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, directed and
// randomized transactions against a byte-level reference model.
module tb_load_store_unit;

  localparam int MEM = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [MEM];
  logic [7:0] ref_mem [MEM];

  int         we_cnt;
  logic [3:0] last_we;
  logic [31:0] last_dw;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata)
  );

  assign drdata = {mem[{daddr[6:2], 2'd3}], mem[{daddr[6:2], 2'd2}],
                   mem[{daddr[6:2], 2'd1}], mem[{daddr[6:2], 2'd0}]};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i])
        mem[{daddr[6:2], 2'(i)}] <= dwdata[8*i +: 8];
  end

  always @(negedge clk) begin
    if (we != 4'b0000) begin
      we_cnt  = we_cnt + 1;
      last_we = we;
      last_dw = dwdata;
    end
  end

  function automatic void ref_txn(input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
    int size;
    longint v;
    rd = 32'd0;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    er = (size == 0) || (st && f3[2]);
    if (!er) er = (a % size) != 0;
    if (!er) er = (longint'(a) + size) > MEM;
    if (er) return;
    if (st) begin
      for (int i = 0; i < size; i++)
        ref_mem[a + i] = wd[8*i +: 8];
      return;
    end
    v = 0;
    for (int i = 0; i < size; i++)
      v = v + (longint'(ref_mem[a + i]) << (8 * i));
    if (!f3[2] && size < 4 && v[8*size-1])
      v = v - (longint'(1) << (8 * size));
    rd = v[31:0];
  endfunction

  task automatic txn(input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    we_cnt = 0;
    last_we = 4'b0000;
    last_dw = 32'd0;
    rd = 32'd0;
    er = 1'b0;
    lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL txn_req_ready timeout addr=%h", a);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 1;
    forever begin
      @(negedge clk);
      if (resp_valid || n > 10) break;
      @(posedge clk);
      n++;
    end
    lat = n;
    if (!resp_valid) begin
      tests++; fails++;
      $display("FAIL txn_resp_valid timeout addr=%h", a);
      return;
    end
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({req_ready, resp_valid, resp_err, we} !== 7'b1000000 ||
        resp_rdata !== 32'd0 || daddr !== 32'd0 || dwdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_in ready=%b v=%b e=%b we=%b rd=%h da=%h dw=%h",
               req_ready, resp_valid, resp_err, we, resp_rdata, daddr, dwdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    tests++;
    if (we !== 4'b1111) begin
      fails++; $display("FAIL reset_pre_we got=%b exp=1111", we);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (we !== 4'b0000 || daddr !== 32'd0) begin
      fails++; $display("FAIL reset_async_we got=%b da=%h exp=0000/0", we, daddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_after ready=%b valid=%b exp=1/0", req_ready, resp_valid);
    end
  endtask

  task automatic chk_txn(input string nm, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    ref_txn(st, f3, a, wd, erd, eer);
    txn(st, f3, a, wd, rd, er, lat);
    tests++;
    if (rd !== erd || er !== eer || lat != 2) begin
      fails++;
      $display("FAIL %s rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=2",
               nm, rd, er, lat, erd, eer);
    end
    tests++;
    if (eer || !st) begin
      if (we_cnt != 0) begin
        fails++; $display("FAIL %s_we_quiet cycles=%0d exp=0", nm, we_cnt);
      end
    end else if (we_cnt != 1) begin
      fails++; $display("FAIL %s_we_once cycles=%0d exp=1", nm, we_cnt);
    end
  endtask

  task automatic test_word();
    chk_txn("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    tests++;
    if (last_we !== 4'b1111 || last_dw !== 32'hDEADBEEF) begin
      fails++; $display("FAIL sw_lanes we=%b dw=%h exp=1111/deadbeef", last_we, last_dw);
    end
    chk_txn("lw_10", 1'b0, 3'b010, 32'h10, 32'h0);
  endtask

  task automatic test_byte();
    chk_txn("sb_13", 1'b1, 3'b000, 32'h13, 32'h000000A5);
    tests++;
    if (last_we !== 4'b1000 || last_dw !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL sb_lanes we=%b dw=%h exp=1000/a5a5a5a5", last_we, last_dw);
    end
    chk_txn("lb_13", 1'b0, 3'b000, 32'h13, 32'h0);
    chk_txn("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0);
    chk_txn("lw_10_after_sb", 1'b0, 3'b010, 32'h10, 32'h0);
  endtask

  task automatic test_half();
    chk_txn("sh_22", 1'b1, 3'b001, 32'h22, 32'h00008001);
    tests++;
    if (last_we !== 4'b1100 || last_dw !== 32'h80018001) begin
      fails++; $display("FAIL sh_lanes we=%b dw=%h exp=1100/80018001", last_we, last_dw);
    end
    chk_txn("lh_22", 1'b0, 3'b001, 32'h22, 32'h0);
    chk_txn("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0);
  endtask

  task automatic test_errors();
    chk_txn("err_lw_11", 1'b0, 3'b010, 32'h11, 32'h0);
    chk_txn("err_sh_21", 1'b1, 3'b001, 32'h21, 32'h1234);
    chk_txn("err_sb_f4", 1'b1, 3'b100, 32'h20, 32'h55);
    chk_txn("err_lw_7e", 1'b0, 3'b010, 32'h7E, 32'h0);
    chk_txn("err_lb_ff", 1'b0, 3'b000, 32'hFFFFFFFF, 32'h0);
    chk_txn("err_f3_011", 1'b0, 3'b011, 32'h0, 32'h0);
    chk_txn("ok_lw_7c", 1'b0, 3'b010, 32'h7C, 32'h0);
  endtask

  task automatic test_backpressure();
    logic [31:0] erd, hold;
    logic eer;
    ref_txn(1'b0, 3'b010, 32'h10, 32'h0, erd, eer);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    hold = resp_rdata;
    tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== erd || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL bp_first v=%b rd=%h e=%b exp 1/%h/0", resp_valid, resp_rdata, resp_err, erd);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (resp_valid !== 1'b1 || resp_rdata !== hold || req_ready !== 1'b0 ||
          daddr !== 32'd0 || we !== 4'b0000) begin
        fails++;
        $display("FAIL bp_hold%0d v=%b rd=%h rdy=%b da=%h exp 1/%h/0/0",
                 i, resp_valid, resp_rdata, req_ready, daddr, hold);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || daddr !== 32'd0 ||
        resp_rdata !== 32'd0) begin
      fails++;
      $display("FAIL bp_release rdy=%b v=%b da=%h rd=%h exp 1/0/0/0",
               req_ready, resp_valid, daddr, resp_rdata);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (daddr !== 32'h10) begin
      fails++; $display("FAIL bp_second_access daddr=%h exp=00000010", daddr);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== erd) begin
      fails++;
      $display("FAIL bp_second_resp v=%b rd=%h exp 1/%h", resp_valid, resp_rdata, erd);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    logic [2:0] f3;
    logic st;
    for (int i = 0; i < 250; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      if ($urandom_range(0, 15) == 0)
        a = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
      else
        a = 32'($urandom_range(0, MEM + 3));
      chk_txn($sformatf("rand%0d", i), st, f3, a, wd);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    we_cnt = 0;
    last_we = 4'b0000;
    last_dw = 32'd0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
